// File: rtl/disp_ch_scheduler_if.sv
// Display channel scheduler bus: mode/selection/request inputs and
// the registered display-select outputs.
interface disp_ch_scheduler_if;
  logic [1:0] mode;      // 00 manual, 01 auto-scan, 10 request-arbitrated, 11 freeze
  logic [2:0] sw_sel;    // manual channel choice
  logic [7:0] req;       // per-channel display request, level-sensitive
  logic [2:0] test_sel;  // selected channel
  logic       latch_en;  // channel-0 latch load enable
  logic [7:0] grant;     // one-hot copy of test_sel
  logic       sel_chg;   // pulse after each test_sel change

  modport master (
    output mode, sw_sel, req,
    input  test_sel, latch_en, grant, sel_chg
  );

  modport slave (
    input  mode, sw_sel, req,
    output test_sel, latch_en, grant, sel_chg
  );
endinterface

// File: rtl/disp_ch_scheduler.sv
// Display channel scheduler: picks which of 8 channels drives the display
// mux, either manually, by timed auto-scan, or by round-robin arbitration
// of requests, with a minimum dwell time per selected channel.
module disp_ch_scheduler #(
  parameter int DWELL = 1024,
  parameter int CNT_W = 26
) (
  input  logic                 clk,
  input  logic                 rst_n,
  disp_ch_scheduler_if.slave   bus
);

  typedef enum logic [1:0] {
    MANUAL = 2'b00,
    SCAN   = 2'b01,
    ARB    = 2'b10,
    FREEZE = 2'b11
  } state_t;

  localparam logic [CNT_W-1:0] DWELL_MAX = CNT_W'(DWELL - 1);

  state_t           state_q, state_d;
  logic [2:0]       sel_q, sel_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       grant_q;
  logic             sel_chg_q;
  logic             latch_en_q;
  logic [2:0]       arb_tgt;
  logic             dwell_done;

  assign dwell_done = (cnt_q == DWELL_MAX);

  // Round-robin search starting at sel_q+1; the current channel (offset 8,
  // which wraps to sel_q) is searched last. Descending loop leaves the
  // smallest matching offset. No requests at all defaults to channel 0.
  always_comb begin
    arb_tgt = 3'd0;
    for (int k = 8; k >= 1; k--) begin
      if (bus.req[sel_q + 3'(k)]) begin
        arb_tgt = sel_q + 3'(k);
      end
    end
  end

  // Next state follows mode; on a mode change only the state moves and the
  // dwell counter clears, so the new mode acts from the following cycle.
  always_comb begin
    state_d = state_t'(bus.mode);
    sel_d   = sel_q;
    cnt_d   = cnt_q;
    if (state_d != state_q) begin
      cnt_d = '0;
    end else begin
      case (state_q)
        MANUAL: begin
          sel_d = bus.sw_sel;
          cnt_d = '0;
        end
        SCAN: begin
          if (dwell_done) begin
            sel_d = sel_q + 3'd1;
            cnt_d = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        ARB: begin
          // Switch only at end of dwell or when the current channel releases;
          // staying on the same channel leaves the counter saturated.
          if ((dwell_done || !bus.req[sel_q]) && (arb_tgt != sel_q)) begin
            sel_d = arb_tgt;
            cnt_d = '0;
          end else if (!dwell_done) begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        default: begin
          // FREEZE: everything holds
        end
      endcase
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= MANUAL;
    end else begin
      state_q <= state_d;
    end
  end

  // Selection, dwell counter and registered outputs derived from next values
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_q      <= 3'd0;
      cnt_q      <= '0;
      grant_q    <= 8'h01;
      sel_chg_q  <= 1'b0;
      latch_en_q <= 1'b1;
    end else begin
      sel_q      <= sel_d;
      cnt_q      <= cnt_d;
      grant_q    <= 8'h01 << sel_d;
      sel_chg_q  <= (sel_d != sel_q);
      latch_en_q <= (state_d != FREEZE) && (sel_d == 3'd0);
    end
  end

  assign bus.test_sel = sel_q;
  assign bus.grant    = grant_q;
  assign bus.sel_chg  = sel_chg_q;
  assign bus.latch_en = latch_en_q;

endmodule

// File: tb/tb_disp_ch_scheduler.sv
// Directed bench for disp_ch_scheduler with DWELL=4.
module tb_disp_ch_scheduler;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;

  disp_ch_scheduler_if dif ();

  disp_ch_scheduler #(.DWELL(4), .CNT_W(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (dif)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    dif.mode = 2'b00; dif.sw_sel = 3'd0; dif.req = 8'h00;
    #1 rst_n = 1'b0;
    #1;
    n_cmp++; if (dif.test_sel !== 3'd0) begin n_err++; $display("FAIL rst_sel: got %0d want 0", dif.test_sel); end
    n_cmp++; if (dif.grant !== 8'h01) begin n_err++; $display("FAIL rst_grant: got %h want 01", dif.grant); end
    n_cmp++; if (dif.latch_en !== 1'b1) begin n_err++; $display("FAIL rst_latch: got %b want 1", dif.latch_en); end
    n_cmp++; if (dif.sel_chg !== 1'b0) begin n_err++; $display("FAIL rst_chg: got %b want 0", dif.sel_chg); end
    #16 rst_n = 1'b1;
    step(1);
    n_cmp++; if (dif.sel_chg !== 1'b0 || dif.test_sel !== 3'd0) begin n_err++; $display("FAIL rst_release: got sel=%0d chg=%b want sel=0 chg=0", dif.test_sel, dif.sel_chg); end
    $display("reset: done");
  endtask

  task automatic test_manual;
    dif.sw_sel = 3'd5;
    step(1);
    n_cmp++; if (dif.test_sel !== 3'd5) begin n_err++; $display("FAIL man_sel: got %0d want 5", dif.test_sel); end
    n_cmp++; if (dif.grant !== 8'h20) begin n_err++; $display("FAIL man_grant: got %h want 20", dif.grant); end
    n_cmp++; if (dif.sel_chg !== 1'b1) begin n_err++; $display("FAIL man_chg: got %b want 1", dif.sel_chg); end
    n_cmp++; if (dif.latch_en !== 1'b0) begin n_err++; $display("FAIL man_latch: got %b want 0", dif.latch_en); end
    step(1);
    n_cmp++; if (dif.sel_chg !== 1'b0 || dif.test_sel !== 3'd5) begin n_err++; $display("FAIL man_hold: got sel=%0d chg=%b want sel=5 chg=0", dif.test_sel, dif.sel_chg); end
    $display("manual: sw_sel=5 -> test_sel=%0d", dif.test_sel);
  endtask

  task automatic test_scan_wrap;
    dif.sw_sel = 3'd6;
    step(1);
    n_cmp++; if (dif.test_sel !== 3'd6) begin n_err++; $display("FAIL scan_start: got %0d want 6", dif.test_sel); end
    dif.mode = 2'b01;
    step(4);
    n_cmp++; if (dif.test_sel !== 3'd6) begin n_err++; $display("FAIL scan_dwell6: got %0d want 6", dif.test_sel); end
    step(1);
    n_cmp++; if (dif.test_sel !== 3'd7 || dif.sel_chg !== 1'b1) begin n_err++; $display("FAIL scan_to7: got sel=%0d chg=%b want sel=7 chg=1", dif.test_sel, dif.sel_chg); end
    step(3);
    n_cmp++; if (dif.test_sel !== 3'd7) begin n_err++; $display("FAIL scan_dwell7: got %0d want 7", dif.test_sel); end
    step(1);
    n_cmp++; if (dif.test_sel !== 3'd0 || dif.grant !== 8'h01 || dif.latch_en !== 1'b1) begin n_err++; $display("FAIL scan_wrap0: got sel=%0d grant=%h latch=%b want sel=0 grant=01 latch=1", dif.test_sel, dif.grant, dif.latch_en); end
    step(3);
    n_cmp++; if (dif.test_sel !== 3'd0 || dif.latch_en !== 1'b1) begin n_err++; $display("FAIL scan_dwell0: got sel=%0d latch=%b want sel=0 latch=1", dif.test_sel, dif.latch_en); end
    step(1);
    n_cmp++; if (dif.test_sel !== 3'd1 || dif.latch_en !== 1'b0) begin n_err++; $display("FAIL scan_to1: got sel=%0d latch=%b want sel=1 latch=0", dif.test_sel, dif.latch_en); end
    $display("scan: 6,7,0,1 sequence ends at %0d", dif.test_sel);
  endtask

  task automatic test_freeze_reset;
    dif.mode = 2'b11; dif.sw_sel = 3'd3;
    step(1);
    n_cmp++; if (dif.test_sel !== 3'd1 || dif.grant !== 8'h02 || dif.latch_en !== 1'b0) begin n_err++; $display("FAIL frz_enter: got sel=%0d grant=%h latch=%b want sel=1 grant=02 latch=0", dif.test_sel, dif.grant, dif.latch_en); end
    step(6);
    n_cmp++; if (dif.test_sel !== 3'd1 || dif.grant !== 8'h02 || dif.sel_chg !== 1'b0) begin n_err++; $display("FAIL frz_hold: got sel=%0d grant=%h chg=%b want sel=1 grant=02 chg=0", dif.test_sel, dif.grant, dif.sel_chg); end
    #3 rst_n = 1'b0;
    #1;
    n_cmp++; if (dif.test_sel !== 3'd0 || dif.grant !== 8'h01 || dif.latch_en !== 1'b1 || dif.sel_chg !== 1'b0) begin n_err++; $display("FAIL frz_async_rst: got sel=%0d grant=%h latch=%b chg=%b want 0/01/1/0", dif.test_sel, dif.grant, dif.latch_en, dif.sel_chg); end
    step(1);
    rst_n = 1'b1;
    step(1);
    n_cmp++; if (dif.test_sel !== 3'd0 || dif.sel_chg !== 1'b0 || dif.latch_en !== 1'b0) begin n_err++; $display("FAIL frz_after_rst: got sel=%0d chg=%b latch=%b want sel=0 chg=0 latch=0", dif.test_sel, dif.sel_chg, dif.latch_en); end
    $display("freeze/reset: sel=%0d latch=%b", dif.test_sel, dif.latch_en);
  endtask

  task automatic test_arb_order;
    dif.mode = 2'b00; dif.sw_sel = 3'd2;
    step(2);
    n_cmp++; if (dif.test_sel !== 3'd2) begin n_err++; $display("FAIL arb_setup: got %0d want 2", dif.test_sel); end
    dif.mode = 2'b10; dif.req = 8'b1000_0010;
    step(1);
    n_cmp++; if (dif.test_sel !== 3'd2) begin n_err++; $display("FAIL arb_modechg: got %0d want 2", dif.test_sel); end
    step(1);
    n_cmp++; if (dif.test_sel !== 3'd7 || dif.grant !== 8'h80) begin n_err++; $display("FAIL arb_to7: got sel=%0d grant=%h want sel=7 grant=80", dif.test_sel, dif.grant); end
    step(3);
    n_cmp++; if (dif.test_sel !== 3'd7) begin n_err++; $display("FAIL arb_dwell7: got %0d want 7", dif.test_sel); end
    step(1);
    n_cmp++; if (dif.test_sel !== 3'd1) begin n_err++; $display("FAIL arb_to1: got %0d want 1", dif.test_sel); end
    step(3);
    n_cmp++; if (dif.test_sel !== 3'd1) begin n_err++; $display("FAIL arb_dwell1: got %0d want 1", dif.test_sel); end
    step(1);
    n_cmp++; if (dif.test_sel !== 3'd7) begin n_err++; $display("FAIL arb_back7: got %0d want 7", dif.test_sel); end
    $display("arb order: 2 -> 7 -> 1 -> %0d", dif.test_sel);
  endtask

  task automatic test_arb_only_current;
    dif.req = 8'h80;
    step(4);
    n_cmp++; if (dif.test_sel !== 3'd7 || dif.sel_chg !== 1'b0) begin n_err++; $display("FAIL arb_self: got sel=%0d chg=%b want sel=7 chg=0", dif.test_sel, dif.sel_chg); end
    step(4);
    n_cmp++; if (dif.test_sel !== 3'd7) begin n_err++; $display("FAIL arb_self_hold: got %0d want 7", dif.test_sel); end
    dif.req = 8'h00;
    step(1);
    n_cmp++; if (dif.test_sel !== 3'd0 || dif.grant !== 8'h01 || dif.latch_en !== 1'b1 || dif.sel_chg !== 1'b1) begin n_err++; $display("FAIL arb_none: got sel=%0d grant=%h latch=%b chg=%b want 0/01/1/1", dif.test_sel, dif.grant, dif.latch_en, dif.sel_chg); end
    $display("arb self/none: sel=%0d", dif.test_sel);
  endtask

  task automatic test_early_release;
    dif.req = 8'h08;
    step(1);
    n_cmp++; if (dif.test_sel !== 3'd3) begin n_err++; $display("FAIL er_to3: got %0d want 3", dif.test_sel); end
    step(1);
    n_cmp++; if (dif.test_sel !== 3'd3 || dif.sel_chg !== 1'b0) begin n_err++; $display("FAIL er_hold3: got sel=%0d chg=%b want sel=3 chg=0", dif.test_sel, dif.sel_chg); end
    dif.req = 8'h20;
    step(1);
    n_cmp++; if (dif.test_sel !== 3'd5) begin n_err++; $display("FAIL er_to5: got %0d want 5", dif.test_sel); end
    step(1);
    dif.req = 8'h00;
    step(1);
    n_cmp++; if (dif.test_sel !== 3'd0) begin n_err++; $display("FAIL er_to0: got %0d want 0", dif.test_sel); end
    $display("early release: 3 -> 5 -> %0d", dif.test_sel);
  endtask

  task automatic test_mode_and_sw;
    dif.mode = 2'b00; dif.sw_sel = 3'd6;
    step(1);
    n_cmp++; if (dif.test_sel !== 3'd0) begin n_err++; $display("FAIL msw_first: got %0d want 0", dif.test_sel); end
    step(1);
    n_cmp++; if (dif.test_sel !== 3'd6) begin n_err++; $display("FAIL msw_second: got %0d want 6", dif.test_sel); end
    $display("mode+sw_sel: sel=%0d", dif.test_sel);
  endtask

  task automatic test_back_to_back;
    for (int i = 1; i <= 3; i++) begin
      dif.sw_sel = 3'(i);
      step(1);
      n_cmp++; if (dif.test_sel !== 3'(i) || dif.sel_chg !== 1'b1) begin n_err++; $display("FAIL b2b_%0d: got sel=%0d chg=%b want sel=%0d chg=1", i, dif.test_sel, dif.sel_chg, i); end
    end
    step(1);
    n_cmp++; if (dif.test_sel !== 3'd3 || dif.sel_chg !== 1'b0) begin n_err++; $display("FAIL b2b_end: got sel=%0d chg=%b want sel=3 chg=0", dif.test_sel, dif.sel_chg); end
    $display("back-to-back: sel=%0d", dif.test_sel);
  endtask

  initial begin
    test_reset();
    test_manual();
    test_scan_wrap();
    test_freeze_reset();
    test_arb_order();
    test_arb_only_current();
    test_early_release();
    test_mode_and_sw();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
